// File: rtl/wb_rf_port_arbiter.sv
// Register-file write-port arbiter: WriteBack always wins, long-latency results
// queue in a small FIFO and drain into idle port cycles.
module wb_rf_port_arbiter #(
    parameter int RWE_SIZE     = 1,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          wb_rd_in,
    input  logic [RWE_SIZE-1:0] wb_we_in,
    input  logic [31:0]         wb_wdata_in,
    input  logic                lu_valid,
    input  logic [4:0]          lu_rd,
    input  logic [31:0]         lu_wdata,
    output logic                lu_ready,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    output logic                raw_hazard,
    output logic                stall_req,
    output logic [4:0]          rf_rd_out,
    output logic [RWE_SIZE-1:0] rf_we_out,
    output logic [31:0]         rf_wdata_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    logic [4:0]            ent_rd_q   [FIFO_DEPTH];
    logic [4:0]            ent_rd_d   [FIFO_DEPTH];
    logic [31:0]           ent_data_q [FIFO_DEPTH];
    logic [31:0]           ent_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_live_q, ent_live_d;
    logic [FIFO_DEPTH-1:0] in_use;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic [4:0]            rf_rd_q, rf_rd_d;
    logic [RWE_SIZE-1:0]   rf_we_q, rf_we_d;
    logic [31:0]           rf_wdata_q, rf_wdata_d;

    logic wb_active, empty, full, accept, pop, push;

    assign wb_active = (|wb_we_in) && (wb_rd_in != 5'd0);
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign lu_ready  = !full;
    assign accept    = lu_valid && !full;

    // A slot is occupied when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off       = PTR_W'(i) - head_q;
            in_use[i] = ({1'b0, off} < count_q);
        end
    end

    always_comb begin
        raw_hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (in_use[i] && ent_live_q[i]) begin
                if ((id_rs != 5'd0 && id_rs == ent_rd_q[i]) ||
                    (id_rt != 5'd0 && id_rt == ent_rd_q[i]))
                    raw_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        ent_live_d = ent_live_q;
        rf_rd_d    = rf_rd_q;
        rf_we_d    = '0;
        rf_wdata_d = rf_wdata_q;
        pop        = 1'b0;

        if (wb_active) begin
            rf_rd_d    = wb_rd_in;
            rf_we_d    = wb_we_in;
            rf_wdata_d = wb_wdata_in;
            // Younger WB value supersedes buffered writes to the same register.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (in_use[i] && ent_rd_q[i] == wb_rd_in)
                    ent_live_d[i] = 1'b0;
            end
        end else if (!empty) begin
            pop = 1'b1;
            if (ent_live_q[head_q]) begin
                rf_rd_d    = ent_rd_q[head_q];
                rf_we_d    = '1;
                rf_wdata_d = ent_data_q[head_q];
            end
        end else if (accept && lu_rd != 5'd0) begin
            rf_rd_d    = lu_rd;
            rf_we_d    = '1;
            rf_wdata_d = lu_wdata;
        end

        // Bypass only happens into an empty, idle port; otherwise buffer it.
        push = accept && (lu_rd != 5'd0) && (wb_active || !empty);
        if (push) begin
            ent_rd_d[tail_q]   = lu_rd;
            ent_data_d[tail_q] = lu_wdata;
            ent_live_d[tail_q] = 1'b1;
        end

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (wb_active && starve_q < LIMIT_C)
            starve_d = starve_q + STV_W'(1);

        stall_d = (starve_q == LIMIT_C) && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
            ent_live_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_we_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            ent_live_q <= ent_live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_rd_q    <= rf_rd_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign stall_req    = stall_q;
    assign rf_rd_out    = rf_rd_q;
    assign rf_we_out    = rf_we_q;
    assign rf_wdata_out = rf_wdata_q;

endmodule
